// File: rtl/router_pkg.sv
// Shared definitions for the router packet source: FSM state encoding,
// header field layout, legal limits and the header-build helper.
package router_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_GAP
  } tx_state_e;

  // Header byte layout: LEN in [7:2], ADDR in [1:0].
  localparam int unsigned HDR_LEN_MSB  = 7;
  localparam int unsigned HDR_LEN_LSB  = 2;
  localparam int unsigned HDR_ADDR_MSB = 1;
  localparam int unsigned HDR_ADDR_LSB = 0;

  localparam logic [1:0]  ADDR_ILLEGAL = 2'd3;
  localparam int unsigned MAX_LEN      = 63;
  localparam int unsigned IDX_W        = 6;

  function automatic logic [7:0] build_header(input logic [5:0] len,
                                              input logic [1:0] addr);
    logic [7:0] hdr;
    hdr = '0;
    hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
    hdr[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
    return hdr;
  endfunction

endpackage

// File: rtl/tx_payload_buf.sv
// Payload store for router_pkt_tx: register array, synchronous write,
// combinational read. Contents are not reset.
//   clk      in  clock
//   wr_en    in  write strobe
//   wr_idx   in  write index
//   wr_data  in  write byte
//   rd_idx   in  read index
//   rd_data  out byte at rd_idx
module tx_payload_buf
  import router_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router input port. Latches a command, buffers
// the payload, then drives header / payload (pkt_valid=1) and XOR parity
// (pkt_valid=0) onto the router bus, stalling on busy.
//   clk, rst              clock, async active-high reset
//   cmd_valid/cmd_ready   command handshake (cmd_addr, cmd_len, cmd_err_inj)
//   pl_valid/pl_ready     payload byte handshake (pl_data)
//   busy                  router stall; bus holds while high
//   pkt_valid, data_out   router bus (registered)
//   tx_done               pulse after parity consumed
//   cmd_err               pulse on accepted illegal-address command
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int unsigned MAX_LEN    = router_pkg::MAX_LEN,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_addr,
  input  logic [5:0] cmd_len,
  input  logic       cmd_err_inj,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic [7:0] pl_data,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       tx_done,
  output logic       cmd_err
);

  tx_state_e  state, state_n;
  logic [1:0] addr_q, addr_n;
  logic [5:0] len_q, len_n;
  logic       err_q, err_n;
  logic [5:0] wr_cnt, wr_n;
  logic [5:0] rd_cnt, rd_n;
  logic [7:0] parity, par_n;
  logic [7:0] gap_cnt, gap_n;
  logic [7:0] data_n;
  logic       pv_n, tx_done_n, cmd_err_n;
  logic       wr_en;
  logic [7:0] rd_data;

  assign cmd_ready = (state == ST_IDLE);
  assign pl_ready  = (state == ST_LOAD);

  tx_payload_buf #(.DEPTH(MAX_LEN + 1)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (wr_cnt),
    .wr_data (pl_data),
    .rd_idx  (rd_cnt),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      parity    <= '0;
      gap_cnt   <= '0;
      data_out  <= '0;
      pkt_valid <= 1'b0;
      tx_done   <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state     <= state_n;
      addr_q    <= addr_n;
      len_q     <= len_n;
      err_q     <= err_n;
      wr_cnt    <= wr_n;
      rd_cnt    <= rd_n;
      parity    <= par_n;
      gap_cnt   <= gap_n;
      data_out  <= data_n;
      pkt_valid <= pv_n;
      tx_done   <= tx_done_n;
      cmd_err   <= cmd_err_n;
    end
  end

  // Bus outputs are registered, so each branch loads the byte that is
  // shown in the *next* state. rd_cnt therefore points at the next
  // payload byte to present, not the one currently on the bus.
  always_comb begin
    state_n   = state;
    addr_n    = addr_q;
    len_n     = len_q;
    err_n     = err_q;
    wr_n      = wr_cnt;
    rd_n      = rd_cnt;
    par_n     = parity;
    gap_n     = gap_cnt;
    data_n    = data_out;
    pv_n      = pkt_valid;
    tx_done_n = 1'b0;
    cmd_err_n = 1'b0;
    wr_en     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_n = cmd_addr;
          len_n  = cmd_len;
          err_n  = cmd_err_inj;
          wr_n   = '0;
          rd_n   = '0;
          if (cmd_addr == ADDR_ILLEGAL) begin
            cmd_err_n = 1'b1;
          end else if (cmd_len == '0) begin
            state_n = ST_HEADER;
            data_n  = build_header(cmd_len, cmd_addr);
            pv_n    = 1'b1;
            par_n   = data_n;
          end else begin
            state_n = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (pl_valid) begin
          wr_en = 1'b1;
          wr_n  = wr_cnt + 6'd1;
          if (wr_n == len_q) begin
            state_n = ST_HEADER;
            data_n  = build_header(len_q, addr_q);
            pv_n    = 1'b1;
            par_n   = data_n;
          end
        end
      end

      ST_HEADER: begin
        if (!busy) begin
          if (len_q == '0) begin
            state_n = ST_PARITY;
            data_n  = parity ^ {7'b0, err_q};
            pv_n    = 1'b0;
          end else begin
            state_n = ST_PAYLOAD;
            data_n  = rd_data;
            rd_n    = rd_cnt + 6'd1;
          end
        end
      end

      ST_PAYLOAD: begin
        if (!busy) begin
          par_n = parity ^ data_out;
          if (rd_cnt == len_q) begin
            state_n = ST_PARITY;
            data_n  = par_n ^ {7'b0, err_q};
            pv_n    = 1'b0;
          end else begin
            data_n = rd_data;
            rd_n   = rd_cnt + 6'd1;
          end
        end
      end

      ST_PARITY: begin
        if (!busy) begin
          state_n   = ST_GAP;
          data_n    = '0;
          tx_done_n = 1'b1;
          gap_n     = '0;
        end
      end

      ST_GAP: begin
        if (gap_cnt == 8'(GAP_CYCLES - 1)) state_n = ST_IDLE;
        else gap_n = gap_cnt + 8'd1;
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule
